// File: rtl/dec_2x4_ack_hold_if.sv
// Handshake bundle between the priority encoder, the 2-to-4 decoder and the line consumer.
// The slave side is the decoder; the master side is the code source plus consumer.
interface dec_2x4_ack_hold_if;
    logic [1:0] in;
    logic       valid;
    logic       ready;
    logic [3:0] out;
    logic       busy;
    logic       ack;
    logic       done;
    logic       timeout;

    modport master (
        output in, valid, ack,
        input  ready, out, busy, done, timeout
    );

    modport slave (
        input  in, valid, ack,
        output ready, out, busy, done, timeout
    );
endinterface

// File: rtl/dec_2x4_ack_hold.sv
// Registered 2-to-4 decoder: drives one line for a guaranteed minimum hold time,
// then waits for the consumer's ack or a timeout before releasing it.
module dec_2x4_ack_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dec_2x4_ack_hold_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LOAD = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic [3:0] out_q, out_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        out_d     = out_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                // Accept only against the registered ready, so one handshake captures one code.
                if (bus.valid && ready_q) begin
                    code_d  = bus.in;
                    out_d   = 4'b0001 << bus.in;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            WAIT: begin
                // ack takes priority over an expiring counter at the same edge.
                if (bus.ack) begin
                    out_d   = 4'b0000;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    out_d     = 4'b0000;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            code_q    <= 2'd0;
            out_q     <= 4'b0000;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;

endmodule

// File: doc/dec_2x4_ack_hold.md
# dec_2x4_ack_hold

Registered 2-to-4 decoder with handshake. It accepts a 2-bit code plus valid from the upstream 4x2 priority encoder, drives the matching one-hot output line for a guaranteed minimum number of cycles, then holds the line until the consumer acknowledges it or a timeout expires. It sits on the receive side of the encoder's {out, valid} interface and dispatches one line at a time.

## Interface
- HOLD_CYCLES, 4: minimum cycles the one-hot line is driven before ack is sampled; legal range 1..255.
- ACK_TIMEOUT, 16: maximum ack-wait cycles after the hold phase; legal range 1..255.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in  input  2  encoded line index; in[1] is the MSB.
- valid  input  1  in is meaningful; handshake completes when valid && ready at an edge.
- ready  output  1  block can accept a code (registered).
- out  output  4  one-hot decoded line; out[k] = 1 iff the captured code is k (registered).
- busy  output  1  high in DRIVE or WAIT.
- ack  input  1  consumer acknowledge (level, sampled only in WAIT).
- done  output  1  one-cycle pulse: line released by ack.
- timeout  output  1  one-cycle pulse: line released by timeout.

## Operation
- FSM states: IDLE, DRIVE, WAIT. Internal 8-bit down-counter cnt. Internal register code_q[1:0].
- Reset (rst_n low at an edge): state=IDLE, out=0, ready=0, busy=0, done=0, timeout=0, cnt=0, code_q=0.
- IDLE:
  - ready is set to 1 at each edge.
  - If valid && ready at an edge: code_q<=in, out<=1<<in, ready<=0, busy<=1, cnt<=HOLD_CYCLES-1, state<=DRIVE.
  - valid while ready=0 (first cycle after reset) is not accepted; the source holds the code.
- DRIVE:
  - out is held and ack is ignored.
  - At each edge: if cnt==0, then cnt<=ACK_TIMEOUT-1 and state<=WAIT; else cnt<=cnt-1.
- WAIT:
  - At an edge with ack=1: out<=0, done<=1, busy<=0, ready<=1, state<=IDLE.
  - Else if cnt==0: out<=0, timeout<=1, busy<=0, ready<=1, state<=IDLE.
  - Else cnt<=cnt-1.
  - ack and timeout at the same edge: ack wins; done=1, timeout=0.
- done and timeout are cleared at every edge where they are not being set (single-cycle pulses).
- valid and in are ignored in DRIVE and WAIT. A new code has no effect on out or code_q.
- out is always 0 or exactly one-hot. It never changes directly from one line to another; a zero cycle always separates them.
- Reset mid-operation forces the reset values at that edge and discards the pending line (no done/timeout pulse).

## Timing
- Accept edge T0 -> out one-hot visible after T0. DRIVE occupies edges T1..T_HOLD_CYCLES. WAIT begins after edge T_HOLD_CYCLES.
- Minimum out-high duration: HOLD_CYCLES+1 cycles, reached when ack is high at the first WAIT edge.
- Maximum out-high duration: HOLD_CYCLES+ACK_TIMEOUT cycles, ending in timeout.
- done/timeout assert in the same cycle out returns to 0. ready returns to 1 in that same cycle.
- Back-to-back throughput: next accept can occur at the edge after the release edge.
- ready deasserts in the cycle after acceptance (registered), so a single valid/ready handshake captures exactly one code.
- After reset release, ready=1 from the first edge with rst_n high.

## Test plan
- Reset: hold rst_n=0 for 3 edges with valid=1, in=2'b11 -> out=0000, ready=0, busy=0, done=0, timeout=0; ready=1 after the first edge with rst_n=1.
- Decode all codes: defaults, ack held high, send in=0..3 back-to-back -> out=0001/0010/0100/1000. Each is high exactly 5 cycles, followed by a done pulse and one zero cycle.
- Hold enforcement: HOLD_CYCLES=4, ack=1 from the accept edge -> ack ignored in DRIVE; out high 5 cycles; done at edge T5.
- Timeout: in=2'b10, ack never asserted, ACK_TIMEOUT=16 -> out=0100 for 20 cycles; timeout pulse for 1 cycle, done=0; ready=1 after release.
- Simultaneous events: ack rises at the final WAIT edge (cnt==0) -> done=1, timeout=0. Also change in to 2'b01 with valid high during WAIT -> out remains 0100.
- Reset mid-operation: rst_n=0 at edge T2 of DRIVE with out=1000 -> out=0, busy=0, no done or timeout pulse; a fresh code accepted after release decodes correctly.
